perm_stage_sched: RTL and testbench
===================================

// Module: perm_stage_sched
// PURPOSE
//  Sequencer for the lane permutation network (permute_benes). Accepts one configuration per NTT stage,
//  then streams cfg_beats lane vectors through the network with valid/ready flow control, generating
//  the per-beat destination map (identity, stride-swap, bit-reverse, rotate). Sits between the
//  butterfly-lane output registers and the memory write-back path; signals completion per stage.
// PARAMETERS
//  N      2*`P   lanes per beat (power of two, 4..32)
//  W      `DW    bits per lane element
//  SELW   `MAP   destination index width, = log2(N)
//  STW    4      stage field width
//  BW     16     beat-count width
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active high
//  cfg_valid  in   1        configuration offered
//  cfg_ready  out  1        scheduler idle, configuration accepted on valid&ready
//  cfg_mode   in   2        0 identity, 1 stride-swap, 2 bit-reverse, 3 rotate
//  cfg_stage  in   STW      stage index s (mode 1 only)
//  cfg_beats  in   BW       number of lane vectors in this stage
//  in_valid   in   1        input beat offered
//  in_ready   out  1        input beat accepted on valid&ready
//  in_data    in   N*W      lane-ordered input vector, lane i at [i*W +: W]
//  out_valid  out  1        permuted beat held in output register
//  out_ready  in   1        downstream accepts on valid&ready
//  out_data   out  N*W      permuted vector: out lane dest[i] = in lane i
//  out_last   out  1        qualifies final beat of the stage
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle pulse when stage fully drained
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, cfg regs=0, acc_cnt=0, out_valid=0, out_data=0, out_last=0,
//   done=0, busy=0; cfg_ready=1 and in_ready=0 once released. Mid-stage reset drops all beats.
//  FSM IDLE/RUN/DRAIN:
//   IDLE : cfg_ready=1. cfg_valid -> latch mode/stage/beats, acc_cnt=0; beats==0 -> DONE, else RUN.
//   RUN  : in_ready = (!out_valid | out_ready). Accept -> acc_cnt++; accepting beat beats-1 -> DRAIN.
//   DRAIN: in_ready=0; out handshake with out_last=1 -> DONE.
//   DONE : single cycle, done=1, cfg_ready=0 -> IDLE. cfg is never accepted in same cycle as done.
//  Datapath: dest map from latched cfg and acc_cnt (combinational), in_data through permute_benes,
//   captured in output register on input accept. Latency exactly 1 cycle (accept at t -> out_valid t+1).
//  Output register: loads on accept; clears out_valid on out handshake without new accept; holds
//   data/last stable while out_valid & !out_ready. Simultaneous out handshake + accept = reload,
//   full throughput 1 beat/cycle. out_last = (acc_cnt == beats-1) at accept.
//  Dest maps (i = lane, SELW bits, mod N):
//   mode0 dest=i; mode1 swap bit0 and bit s of i (s==0 or s>=SELW -> identity);
//   mode2 dest=bitrev_SELW(i); mode3 dest=(i + acc_cnt[SELW-1:0]) mod N (wraps per beat).
//  All maps are bijections; permute_benes requires it. Counters BW wide; beats up to 2^BW-1.
//  in_valid in IDLE/DRAIN/DONE ignored (in_ready=0). cfg_* ignored unless IDLE.
// STRUCTURE
//  Shared header parameter.v: mode encodings PM_IDENT/PM_SWAP/PM_BREV/PM_ROT, state encodings.
//  Sub-module perm_dest_gen (combinational: mode, stage, rot -> N*SELW dest_bus).
//  Instance of permute_benes (N, W, SELW) between dest gen and output register.
// TESTING
//  N=8,W=8. mode0 beats=3, in lanes 0..7 values 10..17, out_ready=1 -> out equal, last on 3rd, done 1 cyc after.
//  mode2 beats=1, in lane i=i -> out {0,4,2,6,1,5,3,7} (lane 0 first), latency 1 cycle.
//  mode1 s=2: in lane i=i -> out {0,4,2,6,1,5,3,7}? no: swap b0,b2 -> out lane k holds {0,4,2,6,1,5,3,7}; s=5 -> identity.
//  mode3 beats=3, in lane i=i each beat -> beat0 identity, beat1 out lane1=0, beat2 out lane2=0.
//  Backpressure: out_ready=0 for 4 cycles mid-stage -> in_ready=0, out_data stable, no beat lost/dup.
//  beats=0 -> no out_valid, done pulse 1 cycle after cfg accept; rst mid-RUN -> all outputs reset values.

Source files
------------

// File: rtl/perm_stage_sched_pkg.sv
// Shared types for the permutation stage scheduler: geometry, mode/state encodings, bit-reverse helper.
// Pure declarations; no timing or flow control of its own.
package perm_stage_sched_pkg;
  localparam int N    = 8;
  localparam int W    = 8;
  localparam int SELW = $clog2(N);
  localparam int STW  = 4;
  localparam int BW   = 16;

  typedef enum logic [1:0] {PM_IDENT = 2'd0, PM_SWAP = 2'd1, PM_BREV = 2'd2, PM_ROT = 2'd3} mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_e;
  typedef logic [SELW-1:0] sel_t;

  function automatic sel_t bitrev(input sel_t x);
    sel_t r;
    for (int b = 0; b < SELW; b++) r[b] = x[SELW-1-b];
    return r;
  endfunction
endpackage

// File: rtl/perm_stage_sched_if.sv
// Handshake bundle of the scheduler: config, input beat and output beat channels plus status.
// slave = scheduler side, master = producer/consumer side.
interface perm_stage_sched_if;
  import perm_stage_sched_pkg::*;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [STW-1:0]   cfg_stage;
  logic [BW-1:0]    cfg_beats;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (output cfg_valid, cfg_mode, cfg_stage, cfg_beats, in_valid, in_data, out_ready,
                  input  cfg_ready, in_ready, out_valid, out_data, out_last, busy, done);
  modport slave  (input  cfg_valid, cfg_mode, cfg_stage, cfg_beats, in_valid, in_data, out_ready,
                  output cfg_ready, in_ready, out_valid, out_data, out_last, busy, done);
endinterface

// File: rtl/perm_stage_sched_dest_gen.sv
// Per-lane destination map from mode/stage/rotation; purely combinational, no flow control.
// Every mode yields a bijection on lane indices.
module perm_stage_sched_dest_gen import perm_stage_sched_pkg::*; (
  input  mode_e               i_mode,
  input  logic [STW-1:0]      i_stage,
  input  sel_t                i_rot,
  output logic [N*SELW-1:0]   o_dest
);
  function automatic sel_t lane_dest(input mode_e m, input logic [STW-1:0] s, input sel_t rot,
                                     input sel_t lane);
    sel_t d;
    d = lane;
    case (m)
      // stage 0 or out-of-range stage leaves the index unchanged
      PM_SWAP: for (int b = 1; b < SELW; b++) begin
        if (s == STW'(b)) begin
          d[0] = lane[b];
          d[b] = lane[0];
        end
      end
      PM_BREV: d = bitrev(lane);
      PM_ROT:  d = lane + rot;
      default: d = lane;
    endcase
    return d;
  endfunction

  always_comb begin
    o_dest = '0;
    for (int i = 0; i < N; i++) begin
      o_dest[i*SELW +: SELW] = lane_dest(i_mode, i_stage, i_rot, sel_t'(i));
    end
  end
endmodule

// File: rtl/permute_benes.sv
// Lane permutation network: output lane dest[i] takes input lane i; combinational, no flow control.
// dest must be a bijection, otherwise lanes collide.
module permute_benes #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = 3
) (
  input  logic [N*W-1:0]    i_data,
  input  logic [N*SELW-1:0] i_dest,
  output logic [N*W-1:0]    o_data
);
  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      o_data[int'(i_dest[i*SELW +: SELW])*W +: W] = i_data[i*W +: W];
    end
  end
endmodule

// File: rtl/perm_stage_sched.sv
// Per-stage sequencer: takes one config, streams cfg_beats vectors through the permutation, pulses done.
// Latency 1 cycle accept->out_valid; in_ready drops while the output register is held by !out_ready.
module perm_stage_sched import perm_stage_sched_pkg::*; (
  input logic                 i_clk,
  input logic                 i_rst,
  perm_stage_sched_if.slave   io
);
  state_e             r_state, w_next;
  mode_e              r_mode;
  logic [STW-1:0]     r_stage;
  logic [BW-1:0]      r_beats, r_acc_cnt;
  logic               r_out_valid, r_out_last;
  logic [N*W-1:0]     r_out_data;
  logic               w_cfg_acc, w_in_rdy, w_in_acc, w_out_hs, w_last_beat;
  logic [N*SELW-1:0]  w_dest;
  logic [N*W-1:0]     w_perm;

  assign w_cfg_acc   = (r_state == ST_IDLE) && io.cfg_valid;
  assign w_in_rdy    = (r_state == ST_RUN) && (!r_out_valid || io.out_ready);
  assign w_in_acc    = w_in_rdy && io.in_valid;
  assign w_out_hs    = r_out_valid && io.out_ready;
  assign w_last_beat = (r_acc_cnt == r_beats - BW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (io.cfg_valid) w_next = (io.cfg_beats == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_in_acc && w_last_beat) w_next = ST_DRAIN;
      ST_DRAIN: if (w_out_hs && r_out_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    io.cfg_ready = (r_state == ST_IDLE);
    io.in_ready  = w_in_rdy;
    io.busy      = (r_state != ST_IDLE);
    io.done      = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode    <= PM_IDENT;
      r_stage   <= '0;
      r_beats   <= '0;
      r_acc_cnt <= '0;
    end else if (w_cfg_acc) begin
      r_mode    <= mode_e'(io.cfg_mode);
      r_stage   <= io.cfg_stage;
      r_beats   <= io.cfg_beats;
      r_acc_cnt <= '0;
    end else if (w_in_acc) begin
      r_acc_cnt <= r_acc_cnt + BW'(1);
    end
  end

  perm_stage_sched_dest_gen u_dest (
    .i_mode  (r_mode),
    .i_stage (r_stage),
    .i_rot   (r_acc_cnt[SELW-1:0]),
    .o_dest  (w_dest)
  );

  permute_benes #(.N(N), .W(W), .SELW(SELW)) u_benes (
    .i_data (io.in_data),
    .i_dest (w_dest),
    .o_data (w_perm)
  );

  // accept has priority: a simultaneous drain and accept reloads for full throughput
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_in_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_perm;
      r_out_last  <= w_last_beat;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;
  assign io.out_last  = r_out_last;
endmodule

// File: tb/tb_perm_stage_sched.sv
// Directed bench for perm_stage_sched with an expected-beat queue checked at each output handshake.
module tb_perm_stage_sched;
  import perm_stage_sched_pkg::*;

  typedef struct packed {
    logic [63:0] dat;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  perm_stage_sched_if bus();
  perm_stage_sched dut (.i_clk(clk), .i_rst(rst), .io(bus));

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   cfg_cyc = 0;
  int   last_hs_neg = -100;

  localparam logic [63:0] LANE_ID  = 64'h0706050403020100;
  localparam logic [63:0] LANE_10  = 64'h11100F0E0D0C0B0A;
  localparam logic [63:0] BREV_OUT = 64'h0703050106020400;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // output lane (i+r) mod 8 takes input lane i
  function automatic logic [63:0] rot_model(input logic [63:0] d, input int r);
    logic [63:0] o;
    logic [7:0]  t;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      t = d[8*i +: 8];
      o[8*((i + r) % 8) +: 8] = t;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_extra: observed beat %h expected none", bus.out_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_data", bus.out_data, mon_e.dat);
        check("out_last", {63'd0, bus.out_last}, {63'd0, mon_e.last});
        if (mon_e.last) last_hs_neg = cyc;
      end
    end
  end

  task automatic reset_check(input string tag);
    check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_out_data"},  bus.out_data, 64'd0);
    check({tag, "_out_last"},  {63'd0, bus.out_last}, 64'd0);
    check({tag, "_done"},      {63'd0, bus.done}, 64'd0);
    check({tag, "_busy"},      {63'd0, bus.busy}, 64'd0);
    check({tag, "_in_ready"},  {63'd0, bus.in_ready}, 64'd0);
    check({tag, "_cfg_ready"}, {63'd0, bus.cfg_ready}, 64'd1);
  endtask

  task automatic send_cfg(input int mode, input int stg, input int beats);
    int k;
    k = 0;
    last_hs_neg = -100;
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'(mode);
    bus.cfg_stage = 4'(stg);
    bus.cfg_beats = 16'(beats);
    @(negedge clk);
    while (!bus.cfg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cfg_ready_wait", {63'd0, bus.cfg_ready}, 64'd1);
    @(posedge clk);
    #1;
    cfg_cyc = cyc;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [63:0] e, input logic last);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    sb.push_back('{dat: e, last: last});
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("latency_1cyc", {63'd0, bus.out_valid}, 64'd1);
  endtask

  // exp_cyc < 0: done is due one cycle after the final output handshake
  task automatic wait_done(input string tag, input int exp_cyc);
    int k;
    int want;
    k = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    want = (exp_cyc < 0) ? last_hs_neg + 1 : exp_cyc;
    check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    check({tag, "_done_cyc"}, 64'(cyc), 64'(want));
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    check({tag, "_idle_again"}, {63'd0, bus.cfg_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] rd;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_stage = 4'd0;
    bus.cfg_beats = 16'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_check("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // identity, three beats, full throughput
    send_cfg(0, 0, 3);
    check("busy_run", {63'd0, bus.busy}, 64'd1);
    for (int b = 0; b < 3; b++) send_beat(LANE_10, LANE_10, b == 2);
    wait_done("ident", -1);

    // bit-reverse and stride-swap produce the same shuffle for s=2 on 8 lanes
    send_cfg(2, 0, 1);
    send_beat(LANE_ID, BREV_OUT, 1'b1);
    wait_done("brev", -1);
    send_cfg(1, 2, 1);
    send_beat(LANE_ID, BREV_OUT, 1'b1);
    wait_done("swap_s2", -1);
    send_cfg(1, 5, 1);
    send_beat(LANE_ID, LANE_ID, 1'b1);
    wait_done("swap_s5", -1);

    // rotate advances by one lane per beat
    send_cfg(3, 0, 3);
    send_beat(LANE_ID, LANE_ID, 1'b0);
    send_beat(LANE_ID, 64'h0605040302010007, 1'b0);
    send_beat(LANE_ID, 64'h0504030201000706, 1'b1);
    wait_done("rot", -1);

    // downstream stall of 4 cycles in the middle of a rotate stage
    send_cfg(3, 0, 8);
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          rd = {$urandom, $urandom};
          send_beat(rd, rot_model(rd, b), b == 7);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.out_data;
        check("bp_valid_held", {63'd0, bus.out_valid}, 64'd1);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
          check("bp_data_stable", bus.out_data, held);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done("bp", -1);

    // empty stage: no beats, done right after the config is taken
    send_cfg(0, 0, 0);
    check("zero_no_valid", {63'd0, bus.out_valid}, 64'd0);
    wait_done("zero", cfg_cyc);

    // reset in the middle of a stage drops everything
    send_cfg(0, 0, 5);
    bus.out_ready = 1'b0;
    send_beat(LANE_10, LANE_10, 1'b0);
    rst = 1'b1;
    #1;
    sb.delete();
    reset_check("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    send_cfg(2, 0, 1);
    send_beat(LANE_ID, BREV_OUT, 1'b1);
    wait_done("post_rst", -1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion before time 100000");
    $fatal(1, "watchdog expired");
  end
endmodule
